seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier for the mini-calculator datapath. Succeeds the 4-bit combinational unsigned multiplier.
- Operand width is set by parameter. A runtime input selects signed (two's complement) or unsigned mode.
- Operands enter and the product leaves through valid/ready handshakes, so the block sits between the operand register stage and the result mux.
- Latency is fixed at WIDTH cycles of computation per operation. No pipelining: one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32). Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b and is_signed are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned
- out_valid  output  1  product is valid
- out_ready  input  1  downstream accepts the product
- product  output  2*WIDTH  result (two's complement if signed mode)

Behaviour:
- Reset: the block enters IDLE. in_ready=1, out_valid=0, product=0, and all internal registers are cleared.
  - Reset is asynchronous. Asserting it mid-operation or while in DONE aborts immediately, and the pending result is discarded.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the block captures the operands:
    - neg = is_signed & (a[MSB] ^ b[MSB]).
    - mcand = |a| and mplier = |b|. The absolute value applies only when is_signed; otherwise the raw operand is used.
    - acc=0, count=0.
  - The state then moves to CALC.
- CALC:
  - in_ready=0. Each edge: if mplier[0]=1, acc += mcand << count; then mplier >>= 1 and count++.
  - After the WIDTH-th CALC edge the state moves to DONE.
  - On that same edge, product is loaded with neg ? -acc : acc, computed in 2*WIDTH bits.
- DONE:
  - out_valid=1. product stays stable while out_ready=0.
  - On an edge with out_ready=1, the state returns to IDLE and out_valid drops. product holds its last value.
- Latency: with accept at edge T, out_valid is high after edge T+WIDTH. No early termination, including when an operand is zero.
- Throughput: one operation per WIDTH+2 cycles minimum. in_ready is 0 in CALC and DONE, so no input is accepted in the same cycle as output handoff.
- Width rules:
  - Unsigned magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH bits unsigned.
  - acc is 2*WIDTH bits and never overflows; the maximum magnitude is (2^WIDTH-1)^2.
- Ignored inputs:
  - a, b and is_signed are ignored outside the IDLE accept edge. Changes during CALC do not affect the result.
  - in_valid held high through DONE is not consumed until the block is back in IDLE.
- out_ready arriving before out_valid has no effect.

Decomposition:
- Package mult_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
  - localparam MAX_WIDTH = 32.
- The counter width is derived in-module as $clog2(WIDTH+1).
- Single module; no sub-module. Datapath and FSM are small enough to stay together.

Test Plan:
- WIDTH=4, unsigned, all 10 legacy pairs, for example 15x15 -> product=8'hE1; 12x11 -> 8'h84; 0x15 -> 8'h00. Each out_valid arrives exactly 4 edges after accept.
- WIDTH=8 signed: -128x-128 -> 16'h4000; -1x127 -> 16'hFF81; 127x-128 -> 16'hC080. The same bit patterns in unsigned mode (8'h80x8'h80) -> 16'h4000, and 8'hFFx8'h7F -> 16'h7E81.
- WIDTH=8 unsigned boundaries: 255x255 -> 16'hFE01; 0x200 -> 16'h0000 with full 8-cycle latency; 1x173 -> 16'h00AD.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, while a and b toggle and in_valid stays high. Required response:
  - product stays stable and in_ready stays 0;
  - the second operation starts only after out_ready=1 and the return to IDLE.
- Reset mid-CALC: assert rst_n=0 on cycle 3 of a 200x3 operation. Required response:
  - immediate IDLE with out_valid=0, product=0, in_ready=1;
  - the next 7x9 operation yields 16'h003F.
- Randomised back-to-back run, 1000 operations with random mode and operands. Every product must match a reference model at both WIDTH=4 and WIDTH=16.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and limits for the sequential multiplier.
// State encoding plus the widest operand the datapath is meant to carry.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, signed or unsigned per operation, one operation in flight.
// Latency: out_valid rises WIDTH edges after the accept edge, regardless of operand values.
// Backpressure: product is held in DONE until out_ready; in_ready stays low through CALC and DONE.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("seq_multiplier: WIDTH must be in 2..%0d", MAX_WIDTH);
  end

  mult_state_t      state;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;
  logic             neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;

  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    a_mag    = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag    = (is_signed && b[WIDTH-1]) ? -b : b;
    addend   = mplier[0] ? (mcand << count) : '0;
    acc_next = acc + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      neg       <= 1'b0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand    <= {{WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == LAST) begin
            product   <= neg ? -acc_next : acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench: three multiplier instances (WIDTH 4, 8, 16) driven in parallel,
// each with its own expected-value queue drained by an independent monitor.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit d4, d8, d16;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Reference product via native multiplication on sign- or zero-extended operands.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    longint ma, mb;
    logic [63:0] m;
    m  = (64'd1 << w) - 64'd1;
    ma = longint'({32'd0, a} & m);
    mb = longint'({32'd0, b} & m);
    if (s) begin
      if (ma >= (longint'(1) << (w - 1))) ma = ma - (longint'(1) << w);
      if (mb >= (longint'(1) << (w - 1))) mb = mb - (longint'(1) << w);
    end
    m = (64'd1 << (2 * w)) - 64'd1;
    return 64'(ma * mb) & m;
  endfunction

  // ---------------- WIDTH=4 lane ----------------
  logic r4, iv4, ir4, s4, ov4, or4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic [7:0] exp4[$];
  int lat4[$];
  bit pv4;

  seq_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(r4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .product(p4)
  );

  always @(negedge clk) begin
    if (!r4) pv4 = 1'b0;
    else begin
      if (ov4 && !pv4) begin
        if (lat4.size() == 0) check("lat_queue4", 64'(lat4.size()), 64'd1);
        else check("latency4", 64'(cyc - lat4.pop_front()), 64'd4);
      end
      if (ov4) begin
        if (exp4.size() == 0) check("exp_queue4", 64'(exp4.size()), 64'd1);
        else begin
          check("product4", 64'(p4), 64'(exp4[0]));
          if (or4) void'(exp4.pop_front());
        end
      end
      pv4 = ov4;
    end
  end

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] e);
    int n = 0;
    bit got = 0;
    @(posedge clk); #1;
    a4 = a; b4 = b; s4 = s; iv4 = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      if (ir4) got = 1; else n++;
    end
    if (got) begin exp4.push_back(e); lat4.push_back(cyc + 1); end
    else check("accept_timeout4", 64'(got), 64'd1);
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
  endtask

  task automatic drain4;
    int n = 0;
    while (exp4.size() != 0 && n < 500) begin @(negedge clk); n++; end
    check("drain4", 64'(exp4.size()), 64'd0);
  endtask

  logic [3:0] la4[10] = '{4'd15, 4'd12, 4'd0, 4'd1, 4'd3, 4'd7, 4'd8, 4'd10, 4'd13, 4'd9};
  logic [3:0] lb4[10] = '{4'd15, 4'd11, 4'd15, 4'd1, 4'd5, 4'd9, 4'd8, 4'd6, 4'd2, 4'd14};
  logic [7:0] le4[10] = '{8'hE1, 8'h84, 8'h00, 8'h01, 8'h0F, 8'h3F, 8'h40, 8'h3C, 8'h1A, 8'h7E};

  initial begin
    or4 = 1'b1;
    @(posedge r4);
    forever begin @(posedge clk); #1; or4 = ($urandom_range(0, 3) != 0); end
  end

  initial begin
    logic [3:0] ra, rb;
    logic rs;
    logic [63:0] r;
    r4 = 1'b1; iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0;
    #1 r4 = 1'b0;
    @(negedge clk);
    check("rst_in_ready4", 64'(ir4), 64'd1);
    check("rst_out_valid4", 64'(ov4), 64'd0);
    check("rst_product4", 64'(p4), 64'd0);
    @(posedge clk); #1 r4 = 1'b1;
    for (int i = 0; i < 10; i++) issue4(la4[i], lb4[i], 1'b0, le4[i]);
    drain4();
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
      r = ref_mul(4, 32'(ra), 32'(rb), rs);
      issue4(ra, rb, rs, r[7:0]);
    end
    drain4();
    d4 = 1'b1;
  end

  // ---------------- WIDTH=8 lane (directed) ----------------
  logic r8, iv8, ir8, s8, ov8, or8;
  logic [7:0] a8, b8;
  logic [15:0] p8;
  logic [15:0] exp8[$];
  int lat8[$];
  bit pv8;

  seq_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(r8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .product(p8)
  );

  always @(negedge clk) begin
    if (!r8) pv8 = 1'b0;
    else begin
      if (ov8 && !pv8) begin
        if (lat8.size() == 0) check("lat_queue8", 64'(lat8.size()), 64'd1);
        else check("latency8", 64'(cyc - lat8.pop_front()), 64'd8);
      end
      if (ov8) begin
        if (exp8.size() == 0) check("exp_queue8", 64'(exp8.size()), 64'd1);
        else begin
          check("product8", 64'(p8), 64'(exp8[0]));
          if (or8) void'(exp8.pop_front());
        end
      end
      pv8 = ov8;
    end
  end

  // Leaves in_valid high and operands unchanged after the accept edge.
  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] e);
    int n = 0;
    bit got = 0;
    @(posedge clk); #1;
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    while (!got && n < 100) begin
      @(negedge clk);
      if (ir8) got = 1; else n++;
    end
    if (got) begin exp8.push_back(e); lat8.push_back(cyc + 1); end
    else check("accept_timeout8", 64'(got), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] e);
    accept8(a, b, s, e);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
  endtask

  task automatic drain8;
    int n = 0;
    while (exp8.size() != 0 && n < 500) begin @(negedge clk); n++; end
    check("drain8", 64'(exp8.size()), 64'd0);
  endtask

  logic [7:0]  va8[8] = '{8'h80, 8'hFF, 8'h7F, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h01};
  logic [7:0]  vb8[8] = '{8'h80, 8'h7F, 8'h80, 8'h80, 8'h7F, 8'hFF, 8'hC8, 8'hAD};
  logic        vs8[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [15:0] ve8[8] = '{16'h4000, 16'hFF81, 16'hC080, 16'h4000, 16'h7E81, 16'hFE01, 16'h0000, 16'h00AD};

  initial begin
    int n, c0;
    r8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
    #1 r8 = 1'b0;
    @(negedge clk);
    check("rst_in_ready8", 64'(ir8), 64'd1);
    check("rst_out_valid8", 64'(ov8), 64'd0);
    check("rst_product8", 64'(p8), 64'd0);
    @(posedge clk); #1 r8 = 1'b1;

    for (int i = 0; i < 8; i++) issue8(va8[i], vb8[i], vs8[i], ve8[i]);
    drain8();
    @(negedge clk);
    check("hold_after_handoff8", 64'(p8), 64'h00AD);

    // Backpressure with toggling operands and in_valid held high throughout.
    @(posedge clk); #1 or8 = 1'b0;
    accept8(8'h12, 8'h34, 1'b0, 16'h03A8);
    n = 0;
    while (!ov8 && n < 50) begin
      a8 = ~a8; b8 = b8 + 8'h5B; s8 = ~s8;
      @(negedge clk);
      check("calc_in_ready8", 64'(ir8), 64'd0);
      @(posedge clk); #1;
      n++;
    end
    check("calc_reached_done8", 64'(ov8), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready8", 64'(ir8), 64'd0);
      check("bp_out_valid8", 64'(ov8), 64'd1);
      @(posedge clk); #1;
      a8 = ~a8; b8 = ~b8; s8 = ~s8;
    end
    or8 = 1'b1;
    c0 = cyc;
    accept8(8'd3, 8'd4, 1'b0, 16'h000C);
    iv8 = 1'b0;
    check("bp_accept_cycle8", 64'(lat8[$] - c0), 64'd2);
    check("bp_order8", 64'(exp8.size()), 64'd1);
    drain8();

    // Asynchronous reset in the third CALC cycle of 200x3.
    issue8(8'd200, 8'd3, 1'b0, 16'h0258);
    repeat (2) @(posedge clk);
    #2;
    r8 = 1'b0;
    exp8.delete();
    lat8.delete();
    #1;
    check("midcalc_rst_in_ready8", 64'(ir8), 64'd1);
    check("midcalc_rst_out_valid8", 64'(ov8), 64'd0);
    check("midcalc_rst_product8", 64'(p8), 64'd0);
    @(posedge clk); #1 r8 = 1'b1;
    issue8(8'd7, 8'd9, 1'b0, 16'h003F);
    drain8();
    d8 = 1'b1;
  end

  // ---------------- WIDTH=16 lane (random) ----------------
  logic r16, iv16, ir16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic [31:0] exp16[$];
  int lat16[$];
  bit pv16;

  seq_multiplier #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(r16), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .product(p16)
  );

  always @(negedge clk) begin
    if (!r16) pv16 = 1'b0;
    else begin
      if (ov16 && !pv16) begin
        if (lat16.size() == 0) check("lat_queue16", 64'(lat16.size()), 64'd1);
        else check("latency16", 64'(cyc - lat16.pop_front()), 64'd16);
      end
      if (ov16) begin
        if (exp16.size() == 0) check("exp_queue16", 64'(exp16.size()), 64'd1);
        else begin
          check("product16", 64'(p16), 64'(exp16[0]));
          if (or16) void'(exp16.pop_front());
        end
      end
      pv16 = ov16;
    end
  end

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [31:0] e);
    int n = 0;
    bit got = 0;
    @(posedge clk); #1;
    a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      if (ir16) got = 1; else n++;
    end
    if (got) begin exp16.push_back(e); lat16.push_back(cyc + 1); end
    else check("accept_timeout16", 64'(got), 64'd1);
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
  endtask

  initial begin
    or16 = 1'b1;
    @(posedge r16);
    forever begin @(posedge clk); #1; or16 = ($urandom_range(0, 3) != 0); end
  end

  initial begin
    logic [15:0] ra, rb;
    logic rs;
    logic [63:0] r;
    int n;
    r16 = 1'b1; iv16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0;
    #1 r16 = 1'b0;
    @(negedge clk);
    check("rst_in_ready16", 64'(ir16), 64'd1);
    check("rst_out_valid16", 64'(ov16), 64'd0);
    check("rst_product16", 64'(p16), 64'd0);
    @(posedge clk); #1 r16 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      r = ref_mul(16, 32'(ra), 32'(rb), rs);
      issue16(ra, rb, rs, r[31:0]);
    end
    n = 0;
    while (exp16.size() != 0 && n < 500) begin @(negedge clk); n++; end
    check("drain16", 64'(exp16.size()), 64'd0);
    d16 = 1'b1;
  end

  // ---------------- completion ----------------
  initial begin
    int n = 0;
    while (!(d4 && d8 && d16) && n < 90000) begin @(posedge clk); n++; end
    check("all_lanes_done", 64'(d4 && d8 && d16), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
